// File: rtl/bias_add_stage.sv
// Adds a per-neuron bias to a streamed accumulator sum, saturates to DATA_W, one register stage.
// Optional macro BIAS_ADD_STAGE_RELU_EN clamps negative results to zero.
module bias_add_stage #(
    parameter int unsigned NUM_NEURONS = 20,
    parameter int unsigned DATA_W      = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_NEURONS*DATA_W-1:0] b_tdata,
    input  logic [DATA_W-1:0]             s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          frame_err
);

    localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int unsigned SUM_W = DATA_W + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    logic              accept;
    logic [DATA_W-1:0] bias_sel;
    logic [SUM_W-1:0]  sum_ext;
    logic [DATA_W-1:0] sat_res;
    logic [DATA_W-1:0] out_res;

    assign s_axis_tready = !valid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Bias word for the neuron currently at the input
    always_comb begin
        bias_sel = '0;
        for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                bias_sel = b_tdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Sign-extended add; the two top bits disagree exactly on overflow
    always_comb begin
        sum_ext = {s_axis_tdata[DATA_W-1], s_axis_tdata} + {bias_sel[DATA_W-1], bias_sel};
        if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
            sat_res = {sum_ext[DATA_W], {(DATA_W-1){~sum_ext[DATA_W]}}};
        end else begin
            sat_res = sum_ext[DATA_W-1:0];
        end
`ifdef BIAS_ADD_STAGE_RELU_EN
        out_res = sat_res[DATA_W-1] ? '0 : sat_res;
`else
        out_res = sat_res;
`endif
    end

    always_comb begin
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = err_q;
        if (accept) begin
            data_d  = out_res;
            valid_d = 1'b1;
            last_d  = s_axis_tlast;
            idx_d   = (s_axis_tlast || idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            if (s_axis_tlast != (idx_q == IDX_LAST)) begin
                err_d = 1'b1;
            end
        end else if (m_axis_tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign frame_err     = err_q;

endmodule
